// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: FSM state codes, field widths,
// special entry values and helpers that split a ROM entry into its fields.
package melody_pkg;

  localparam int CODE_W_DEF = 5;
  localparam int DUR_W_DEF  = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_PLAY   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_PAUSED = 3'd5;

  // Code 0 is a rest; duration 0 marks the end of the song.
  localparam int REST_CODE = 0;
  localparam int END_DUR   = 0;

  // Entry layout is {note_code, duration}; duration occupies the low dur_w bits.
  function automatic logic [31:0] entry_code(input logic [31:0] entry, input int dur_w);
    return entry >> dur_w;
  endfunction

  function automatic logic [31:0] entry_dur(input logic [31:0] entry, input int dur_w);
    return entry & ((32'd1 << dur_w) - 32'd1);
  endfunction

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// Beat timer: counts 0..CNT_MAX-1 while enabled and pulses tick_o on the
// last count. A load value lets the same counter time the silent gap by
// starting part-way through a beat.
module beat_timer #(
  parameter int CNT_MAX = 625_000,
  parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CNT_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST_CNT);
  assign tick_o  = en_i && at_last;
  assign cnt_o   = cnt_q;

  // Next count: clear beats load, load beats counting, wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a synchronous note ROM, holds each note for its
// beat count, silences the tail of the last beat as an articulation gap and
// honours start / pause / stop. Define MELODY_LOOP_EN to repeat the song at
// the end marker instead of returning to idle.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int CODE_W       = CODE_W_DEF,
  parameter int DUR_W        = DUR_W_DEF,
  parameter int BEAT_CNT_MAX = 625_000,
  parameter int GAP_CNT      = 25_000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    stop,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [CODE_W+DUR_W-1:0] rom_data,
  output logic [CODE_W-1:0]       note_code,
  output logic                    note_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = (BEAT_CNT_MAX > 1) ? $clog2(BEAT_CNT_MAX) : 1;
  // Last count of the sounding part of the final beat, and where the gap resumes.
  localparam logic [CNT_W-1:0] PLAY_END  = CNT_W'(BEAT_CNT_MAX - GAP_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_CNT_MAX - GAP_CNT);

  logic [2:0]        state_q, state_d;
  logic [2:0]        saved_q, saved_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CODE_W-1:0] code_q,  code_d;
  logic              valid_q, valid_d;
  logic [DUR_W-1:0]  beats_q, beats_d;
  logic              done_c;

  logic              tmr_clr, tmr_en, tmr_load, tmr_tick;
  logic [CNT_W-1:0]  tmr_cnt;

  logic [CODE_W-1:0] rd_code;
  logic [DUR_W-1:0]  rd_dur;
  logic              end_mark;

  assign rd_code  = CODE_W'(entry_code(32'(rom_data), DUR_W));
  assign rd_dur   = DUR_W'(entry_dur(32'(rom_data), DUR_W));
  assign end_mark = (rd_dur == DUR_W'(END_DUR));

  beat_timer #(
    .CNT_MAX (BEAT_CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_beat_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .load_i     (tmr_load),
    .load_val_i (GAP_START),
    .cnt_o      (tmr_cnt),
    .tick_o     (tmr_tick)
  );

  // Playback FSM: normal sequencing first, then pause capture, then stop override.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    addr_d   = addr_q;
    code_d   = code_q;
    valid_d  = valid_q;
    beats_d  = beats_q;
    done_c   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    tmr_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (start) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tmr_clr = 1'b1;
        if (end_mark) begin
          done_c = !sys_rst;
          addr_d = '0;
`ifdef MELODY_LOOP_EN
          state_d = ST_FETCH;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          code_d  = rd_code;
          valid_d = (rd_code != CODE_W'(REST_CODE));
          beats_d = rd_dur;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        tmr_en = 1'b1;
        if ((beats_q == DUR_W'(1)) && (tmr_cnt == PLAY_END)) begin
          // The gap occupies the tail of the final beat; the timer jumps there.
          tmr_load = 1'b1;
          valid_d  = 1'b0;
          state_d  = ST_GAP;
        end else if (tmr_tick) begin
          beats_d = beats_q - DUR_W'(1);
        end
      end
      ST_GAP: begin
        tmr_en = 1'b1;
        if (tmr_tick) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = saved_q;
          valid_d = (saved_q == ST_PLAY) && (code_q != CODE_W'(REST_CODE));
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The pausing cycle still counts, so sounding time is preserved exactly.
    if (((state_q == ST_PLAY) || (state_q == ST_GAP)) && pause &&
        ((state_d == ST_PLAY) || (state_d == ST_GAP))) begin
      saved_d = state_d;
      state_d = ST_PAUSED;
      valid_d = 1'b0;
    end

    if (stop) begin
      state_d  = ST_IDLE;
      saved_d  = ST_IDLE;
      addr_d   = '0;
      code_d   = '0;
      valid_d  = 1'b0;
      beats_d  = '0;
      done_c   = 1'b0;
      tmr_clr  = 1'b1;
      tmr_en   = 1'b0;
      tmr_load = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      addr_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      beats_q <= beats_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note_code  = code_q;
  assign note_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_c;

endmodule
